// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
// ---------------
// Round-robin arbiter and select sequencer for an 8:1 multiplexer datapath.
// Eight requesters compete for one shared mux. One requester is granted at a
// time. A programmable hold limit forces the grant to rotate when others are
// waiting. The block also registers the selected data bit.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles while other requests are
//             pending (0..255). A value of 0 disables the limit.
//
// Ports:
//   clk      in   1  system clock; all state updates on the rising edge
//   rst      in   1  synchronous, active-high reset
//   req      in   8  request vector; req[i] is high while requester i wants the mux
//   d_in     in   8  mux data inputs; d_in[i] belongs to requester i
//   grant    out  8  registered one-hot grant; zero when idle
//   sel      out  3  registered mux select; index of the granted requester
//   busy     out  1  high while a grant is active
//   d_out    out  1  registered d_in[sel]
//   d_valid  out  1  high when d_out holds a sample taken during a grant

module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] d_in,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       d_out,
  output logic       d_valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // The hold counter value at which a contended grant must be given up. The
  // comparison is only enabled when a limit is configured.
  localparam logic       HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       d_out_q, d_out_d;
  logic       d_valid_q, d_valid_d;

  logic [7:0] others;
  logic       natural_rel;
  logic       forced_rel;

  // Return the first set bit of v, scanning upward from start and wrapping
  // modulo 8. The loop runs from the farthest offset to the nearest, so the
  // nearest set bit is the last one written and therefore wins.
  function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] start);
    logic [2:0] idx;
    pick = start;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (v[idx]) pick = idx;
    end
  endfunction

  // Next-state and output logic. The release check comes before the hold
  // counter update. When a grant is released and another request is
  // pending, the next requester is granted in the same cycle, so no idle
  // cycle appears between grants.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    others      = req & ~grant_q;
    natural_rel = 1'b0;
    forced_rel  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req != 8'h00) begin
          sel_d      = pick(req, ptr_q);
          grant_d    = 8'h01 << sel_d;
          hold_cnt_d = 8'h00;
          state_d    = GRANT;
        end
      end

      GRANT: begin
        natural_rel = ~req[sel_q];
        forced_rel  = HOLD_EN && (hold_cnt_q == HOLD_LAST) && (others != 8'h00);
        if (natural_rel || forced_rel) begin
          ptr_d      = sel_q + 3'd1;
          hold_cnt_d = 8'h00;
          if (others != 8'h00) begin
            sel_d   = pick(others, sel_q + 3'd1);
            grant_d = 8'h01 << sel_d;
          end else begin
            state_d = IDLE;
            grant_d = 8'h00;
            sel_d   = 3'd0;
          end
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == GRANT);
  end

  // The data path samples the currently selected input while a grant is
  // active. d_valid trails busy by one cycle, so the last sample taken in a
  // grant is still flagged valid after that grant ends.
  always_comb begin
    d_valid_d = busy_q;
    d_out_d   = busy_q ? d_in[sel_q] : d_out_q;
  end

  // State register. The synchronous reset takes priority over everything,
  // including a grant in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      hold_cnt_q <= 8'h00;
      grant_q    <= 8'h00;
      sel_q      <= 3'd0;
      busy_q     <= 1'b0;
      d_out_q    <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      d_out_q    <= d_out_d;
      d_valid_q  <= d_valid_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign d_out   = d_out_q;
  assign d_valid = d_valid_q;

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and select sequencer for the 8:1 multiplexer datapath. Eight requesters compete for the shared mux. The block grants one requester at a time, drives the 3-bit mux select and one-hot grant, and registers the selected data bit. A programmable hold limit forces rotation so that no requester starves the others.

## Interface
Parameters:
- MAX_HOLD, default 16: maximum consecutive grant cycles while other requests are pending. Legal range 0..255. 0 means no limit.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; req[i] is held high while requester i wants the mux.
- d_in  input  8  mux data inputs; d_in[i] belongs to requester i.
- grant  output  8  one-hot grant, registered; all zeros when idle.
- sel  output  3  mux select, registered; equals the index of the granted requester.
- busy  output  1  high while in GRANT.
- d_out  output  1  registered d_in[sel].
- d_valid  output  1  high when d_out holds a sample taken during a grant.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - ptr[2:0]: highest-priority index.
  - hold_cnt[7:0]: consecutive cycles in the current grant.
- Reset values (assigned at the edge where rst=1): state=IDLE, ptr=0, hold_cnt=0, grant=8'h00, sel=0, busy=0, d_out=0, d_valid=0. rst has priority over every other event, including mid-grant; the next grant after reset searches from index 0.
- Search function pick(v, start): the first set bit of v scanning start, start+1, …, 7, 0, …, start-1 (mod 8).
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise: sel=pick(req, ptr), grant=1<<sel, hold_cnt=0, go to GRANT.
- GRANT: on each edge, evaluate in this order.
  - Natural release: req[sel]==0.
  - Forced release: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (req & ~grant)!=0.
  - On either release:
    - ptr=sel+1 (wraps 7→0).
    - Let others=req & ~grant.
    - others!=0: grant pick(others, sel+1) back-to-back with no idle cycle, and reset hold_cnt to 0.
    - others==0: go to IDLE with grant=0, sel=0, busy=0.
  - Otherwise: stay, and hold_cnt increments, saturating at 255.
- A forced-release requester that keeps req high gets lowest priority and re-competes normally.
- With a single requester, there is never a forced release, regardless of MAX_HOLD.
- Requests arriving while another requester holds the grant are only considered at a release.
- Data path, on every edge:
  - d_valid <= busy.
  - d_out <= d_in[sel] if busy, else d_out holds its value.
- Invariants:
  - grant is one-hot or zero.
  - grant!=0 ⇔ busy.
  - sel==log2(grant) when busy.

## Timing
- Request to grant: 1 cycle. If req is sampled high at edge N, grant, sel and busy are valid after edge N.
- Release:
  - If req[sel] is sampled low at edge N, grant changes after edge N.
  - The handover to the next requester completes in the same edge, giving 0 idle cycles.
- Forced rotation: a contended grant lasts exactly MAX_HOLD cycles.
- Data latency: 1 cycle. d_out after edge N+1 equals d_in[sel] sampled at edge N+1 while grant was active; d_valid is aligned with it.
- After a grant ends, d_valid stays high for one more cycle. This covers the final sample.
- Simultaneous events: the release decision and new requests sampled at the same edge are resolved by that edge.
  - Example: req[sel] drops while req[j] rises; j is granted immediately.

## Test plan
- Reset and idle:
  - Stimulus: rst=1 for 2 cycles, then req=0.
  - Response: grant=0, sel=0, busy=0, d_valid=0 on every cycle.
- Single grant and data:
  - Stimulus: req=8'h08 from cycle 1 to cycle 5, d_in=8'h08.
  - Response: grant=8'h08 and sel=3 one cycle later. d_out=1 and d_valid=1 follow one cycle behind. IDLE is reached one cycle after req drops.
- Round-robin order:
  - Stimulus: req=8'h91 held. Each requester drops its req 3 cycles after being granted and re-raises it the next cycle.
  - Response: grant sequence 8'h01→8'h10→8'h80→8'h01 with no idle gaps.
- Forced rotation:
  - Stimulus: MAX_HOLD=4, req=8'h06 held constant.
  - Response: grant is 8'h02 for exactly 4 cycles, then 8'h04 for exactly 4 cycles, alternating indefinitely.
- No-limit and lone requester:
  - Stimulus: MAX_HOLD=0 with req=8'h03 held for 50 cycles, then MAX_HOLD=4 with req=8'h20 alone for 20 cycles.
  - Response: the grant never rotates in either case.
- Reset mid-grant:
  - Stimulus: req=8'h40 granted, then rst pulsed for 1 cycle while req=8'h41.
  - Response: grant=0 after the reset edge. Next grant is 8'h01, because ptr is back at 0.
